dffe_pipe: RTL

- Parametrised successor to the single-bit enabled D flip-flop.
- WIDTH-bit data, DEPTH-stage enabled delay line with per-stage valid tracking, global advance enable, flush and an occupancy count.
- Used wherever a bus must be delayed or aligned by a fixed number of enabled clocks, e.g. matching data to a multi-cycle control path, with stalls via en.

---
 rtl/dffe_pkg.sv | 30 +++
 rtl/dffe_stage.sv | 45 ++++
 rtl/dffe_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/dffe_pkg.sv
// Shared types and helpers for the dffe_pipe delay line.
// Optional feature macro: DFFE_PIPE_PARITY_EN (adds a per-stage parity bit).
package dffe_pkg;

    // Widest data word the parity helper accepts. Narrower words are
    // zero-extended, which leaves the XOR result unchanged.
    localparam int PAR_MAX_W = 1024;

    // Control part of a stage record. The data word travels next to it as
    // a WIDTH-bit vector, because WIDTH is chosen per instance and a package
    // typedef cannot depend on it.
    typedef struct packed {
`ifdef DFFE_PIPE_PARITY_EN
        logic par;
`endif
        logic vld;
    } stage_tag_t;

    // Width of the occupancy counter, which must represent 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Even-parity bit: XOR of all data bits, so data plus parity has an
    // even number of ones.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dffe_stage.sv
// One stage of the dffe_pipe delay line: a WIDTH-bit data register plus its
// valid bit (and a parity bit when DFFE_PIPE_PARITY_EN is defined).
module dffe_stage
    import dffe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             flush_vld,
    input  logic [WIDTH-1:0] in_data,
    input  stage_tag_t       in_tag,
    output logic [WIDTH-1:0] out_data,
    output stage_tag_t       out_tag
);

    logic [WIDTH-1:0] data_r;
    stage_tag_t       tag_r;

    // Data and its tag are captured on en. Flush only drops the valid bit and
    // overrides a valid that would otherwise be shifted in on the same edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            data_r    <= RST_VAL;
            tag_r.vld <= 1'b0;
`ifdef DFFE_PIPE_PARITY_EN
            tag_r.par <= even_parity(PAR_MAX_W'(RST_VAL));
`endif
        end else begin
            if (en) begin
                data_r <= in_data;
                tag_r  <= in_tag;
            end
            if (flush_vld) begin
                tag_r.vld <= 1'b0;
            end
        end
    end

    assign out_data = data_r;
    assign out_tag  = tag_r;

endmodule

// File: rtl/dffe_pipe.sv
// dffe_pipe: DEPTH-stage enabled delay line for a WIDTH-bit bus, with
// per-stage valid tracking, flush and a registered occupancy count.
// Optional feature macro: DFFE_PIPE_PARITY_EN adds per-stage even parity and
// a registered q_perr output.
module dffe_pipe
    import dffe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    output logic [CW-1:0]    count
`ifdef DFFE_PIPE_PARITY_EN
    ,
    output logic             q_perr
`endif
);

    logic [WIDTH-1:0] st_data [DEPTH];
    stage_tag_t       st_tag  [DEPTH];
    stage_tag_t       in_tag0;
    logic [CW-1:0]    count_r;

    // Build the record entering stage 0 from the input bus.
    always_comb begin
        in_tag0     = '0;
        in_tag0.vld = d_vld;
`ifdef DFFE_PIPE_PARITY_EN
        in_tag0.par = even_parity(PAR_MAX_W'(d));
`endif
    end

    // Stage chain: stage 0 is fed from the input, every other stage from its
    // predecessor. Flush is applied to every stage simultaneously.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            dffe_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk       (clk),
                .clr       (clr),
                .en        (en),
                .flush_vld (flush),
                .in_data   (d),
                .in_tag    (in_tag0),
                .out_data  (st_data[i]),
                .out_tag   (st_tag[i])
            );
        end else begin : g_body
            dffe_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk       (clk),
                .clr       (clr),
                .en        (en),
                .flush_vld (flush),
                .in_data   (st_data[i-1]),
                .in_tag    (st_tag[i-1]),
                .out_data  (st_data[i]),
                .out_tag   (st_tag[i])
            );
        end
    end

    assign q     = st_data[DEPTH-1];
    assign q_vld = st_tag[DEPTH-1].vld;

    // Occupancy: one in when a valid word enters, one out when the valid
    // word on q is shifted away. A full pipe taking a valid word nets zero,
    // so the count cannot exceed DEPTH.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CW'(d_vld) - CW'(q_vld);
        end
    end

    assign count = count_r;

`ifdef DFFE_PIPE_PARITY_EN
    logic [WIDTH-1:0] last_in_data;
    stage_tag_t       last_in_tag;

    // Record about to be loaded into the last stage; checking it one edge
    // early keeps q_perr aligned with the word it describes.
    if (DEPTH == 1) begin : g_last_in_head
        assign last_in_data = d;
        assign last_in_tag  = in_tag0;
    end else begin : g_last_in_body
        assign last_in_data = st_data[DEPTH-2];
        assign last_in_tag  = st_tag[DEPTH-2];
    end

    // Registered parity check of the word that will sit on q; held on stall.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            q_perr <= 1'b0;
        end else if (en) begin
            q_perr <= last_in_tag.vld &
                      (even_parity(PAR_MAX_W'(last_in_data)) != last_in_tag.par);
        end
    end
`endif

endmodule
